boletim_notas: RTL and testbench
================================

# boletim_notas

Parametrised grade-book block for the FPGA lab top level. It captures student grades entered on the switches, one per rising edge of a capture switch, into an internal buffer of up to `MAX_ALUNOS` entries, and keeps per-category tallies and a running sum. It drives the 7-segment display with the A/F/P letter for one of four selectable sources: live input, last stored grade, class average, or a stepped review of stored grades. It replaces the purely combinational single-grade classifier.

## Interface
- `NOTA_W`, 4: grade width in bits.
- `NOTA_MAX`, 10: highest legal grade; larger values are rejected.
- `MAX_ALUNOS`, 16: buffer depth; legal range 1..31.
- `LIMIAR_A`, 7: grade >= this is category A.
- `LIMIAR_F`, 4: grade >= this and < `LIMIAR_A` is category F; below it is P.
- `SEG_A` 'h77, `SEG_F` 'h71, `SEG_P` 'h73, `SEG_VAZIO` 'h00: display patterns.
- `clk_2`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `nota_in`  in  `NOTA_W`  grade value (from SWI).
- `captura`  in  1  level switch; its rising edge stores `nota_in`.
- `proximo`  in  1  level switch; its rising edge advances the review pointer.
- `limpa`  in  1  synchronous functional clear, level-sensitive.
- `modo`  in  2  display source select.
- `SEG`  out  8  7-segment pattern.
- `LED`  out  8  status: [7] cheio, [6] overflow, [5] rejeitada, [4:0] count.
- `n_A`, `n_F`, `n_P`  out  5 each  per-category counts.

## Operation
- Edge detection: registers `captura_q` and `proximo_q` sample the inputs every cycle. A capture event is `captura & ~captura_q`; a step event is `proximo & ~proximo_q`.
- FSM states:
  - VAZIO: count = 0.
  - COLETA: 0 < count < `MAX_ALUNOS`.
  - CHEIO: count = `MAX_ALUNOS`.
- FSM transitions:
  - VAZIO -> COLETA on the first accepted capture.
  - COLETA -> CHEIO when the accepted capture makes count = `MAX_ALUNOS`.
  - Any state -> VAZIO on `limpa`.
- Accepted capture: requires a capture event, `nota_in` <= `NOTA_MAX`, and state != CHEIO. On acceptance:
  - write `buf[count]`;
  - count += 1 and sum += `nota_in` (sum width `NOTA_W`+5, no overflow possible);
  - increment the matching `n_A`/`n_F`/`n_P`;
  - `ultima` <= `nota_in`.
- Rejected capture:
  - `nota_in` > `NOTA_MAX`: sets sticky `rejeitada`; nothing is stored.
  - Capture event while CHEIO: sets sticky `overflow`; nothing is stored.
- Classification function cls(g): A if g >= `LIMIAR_A`; else F if g >= `LIMIAR_F`; else P.
- Average category: no division is performed.
  - A if sum >= `LIMIAR_A`*count;
  - else F if sum >= `LIMIAR_F`*count;
  - else P.
- Review pointer `ptr`:
  - On a step event with count > 0: `ptr` <= (`ptr` == count-1) ? 0 : `ptr`+1.
  - On a step event with count = 0: `ptr` is unchanged.
- `SEG` by `modo`:
  - 0: cls(`nota_in`), combinational, always valid.
  - 1: cls(`ultima`).
  - 2: average category.
  - 3: cls(`buf[ptr]`).
  - Modes 1-3 output `SEG_VAZIO` when count = 0.
- `LED` is combinational from the registered state: {cheio, overflow, rejeitada, count[4:0]}.

## Timing
- `reset` (priority 1):
  - count, sum, `n_*`, `ptr`, `ultima` and the flags go to 0; state goes to VAZIO.
  - `captura_q` and `proximo_q` go to 1, so a switch held high through reset causes no capture.
  - `buf` contents are don't-care.
  - After reset: `LED` = 'h00; `SEG` = `SEG_VAZIO` in modes 1-3.
- `limpa` (priority 2): same clear as `reset` except the edge registers keep sampling normally. A capture event in the same cycle is discarded.
- Capture latency: an edge sampled at clock edge n produces updated count, sum, `n_*`, `ultima`, `LED` and `SEG` (modes 1-3) after edge n, i.e. visible in cycle n+1.
- Capture and step events in the same cycle: both take effect. `ptr` wraps against the pre-capture count.
- Mode 0 has zero latency; a `modo` change takes effect combinationally.
- Holding `captura` high stores exactly one grade. A new capture requires low then high.

## Test plan
- Reset with `captura`=1 held, then release reset: no capture occurs; `LED`='h00; `modo`=1 gives `SEG`='h00.
- Capture 9, 5, 2 (`modo`=1 after each): `SEG` = 'h77, 'h71, 'h73. Then `n_A`=1, `n_F`=1, `n_P`=1, `LED`[4:0]=3, sum=16.
- `modo`=2 with grades {9,5,2}: 16 < 21 and 16 >= 12, so `SEG`='h71. Add grade 10: 26 >= 16 but < 28, so `SEG` stays 'h71.
- Capture `nota_in`=12: count is unchanged; `LED`[5]=1, and it stays set after a later valid capture.
- `MAX_ALUNOS`=4: fill with four grades, then capture again. Expect `LED`='hC4 (cheio, overflow, count 4) and `buf` unchanged.
- `modo`=3 with grades {9,5,2}: step events give `SEG` 'h71, 'h73, 'h77 (`ptr` wraps to 0). Then assert `limpa`: `LED`='h00 and `SEG`='h00.

Source files
------------

// File: rtl/boletim_notas.sv
// Grade book: captures grades on rising edges of a switch, keeps per-category
// tallies and a running sum, and shows the A/F/P letter for one of four sources.
module boletim_notas #(
  parameter int unsigned NOTA_W     = 4,
  parameter int unsigned NOTA_MAX   = 10,
  parameter int unsigned MAX_ALUNOS = 16,
  parameter int unsigned LIMIAR_A   = 7,
  parameter int unsigned LIMIAR_F   = 4,
  parameter logic [7:0]  SEG_A      = 8'h77,
  parameter logic [7:0]  SEG_F      = 8'h71,
  parameter logic [7:0]  SEG_P      = 8'h73,
  parameter logic [7:0]  SEG_VAZIO  = 8'h00
) (
  input  logic              clk_2,
  input  logic              reset,
  input  logic [NOTA_W-1:0] nota_in,
  input  logic              captura,
  input  logic              proximo,
  input  logic              limpa,
  input  logic [1:0]        modo,
  output logic [7:0]        SEG,
  output logic [7:0]        LED,
  output logic [4:0]        n_A,
  output logic [4:0]        n_F,
  output logic [4:0]        n_P
);

  localparam int unsigned SUM_W  = NOTA_W + 5;
  // Wide enough for LIMIAR * count (LIMIAR < 2**NOTA_W, count < 32).
  localparam int unsigned PROD_W = NOTA_W + 6;
  localparam int unsigned IDX_W  = (MAX_ALUNOS > 1) ? $clog2(MAX_ALUNOS) : 1;

  localparam logic [1:0] VAZIO  = 2'd0;
  localparam logic [1:0] COLETA = 2'd1;
  localparam logic [1:0] CHEIO  = 2'd2;

  localparam logic [NOTA_W-1:0] NOTA_MAX_V = NOTA_MAX[NOTA_W-1:0];
  localparam logic [NOTA_W-1:0] LIM_A_V    = LIMIAR_A[NOTA_W-1:0];
  localparam logic [NOTA_W-1:0] LIM_F_V    = LIMIAR_F[NOTA_W-1:0];
  localparam logic [4:0]        MAX_V      = MAX_ALUNOS[4:0];

  logic [1:0]        state_q, state_d;
  logic [4:0]        count_q, count_d;
  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [4:0]        na_q, na_d, nf_q, nf_d, np_q, np_d;
  logic [4:0]        ptr_q, ptr_d;
  logic [NOTA_W-1:0] ultima_q, ultima_d;
  logic              ovf_q, ovf_d, rej_q, rej_d;
  logic              captura_q, proximo_q;

  logic [NOTA_W-1:0] notas [MAX_ALUNOS];

  logic cap_ev, step_ev, cheio, nota_ok, aceita;
  logic [PROD_W-1:0] sum_ext, prod_a, prod_f;

  function automatic logic [7:0] cls(input logic [NOTA_W-1:0] g);
    if (g >= LIM_A_V)      return SEG_A;
    else if (g >= LIM_F_V) return SEG_F;
    else                   return SEG_P;
  endfunction

  // Event detection and capture acceptance.
  always_comb begin
    cap_ev  = captura & ~captura_q;
    step_ev = proximo & ~proximo_q;
    cheio   = (state_q == CHEIO);
    nota_ok = (nota_in <= NOTA_MAX_V);
    aceita  = cap_ev & nota_ok & ~cheio & ~limpa;
  end

  // Next-state for counters, flags, review pointer and FSM.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    sum_d    = sum_q;
    na_d     = na_q;
    nf_d     = nf_q;
    np_d     = np_q;
    ptr_d    = ptr_q;
    ultima_d = ultima_q;
    ovf_d    = ovf_q;
    rej_d    = rej_q;
    if (limpa) begin
      state_d  = VAZIO;
      count_d  = '0;
      sum_d    = '0;
      na_d     = '0;
      nf_d     = '0;
      np_d     = '0;
      ptr_d    = '0;
      ultima_d = '0;
      ovf_d    = 1'b0;
      rej_d    = 1'b0;
    end else begin
      // Wrap is decided against the pre-capture count.
      if (step_ev && count_q != 5'd0) begin
        ptr_d = (ptr_q == count_q - 5'd1) ? 5'd0 : ptr_q + 5'd1;
      end
      if (cap_ev && !nota_ok) rej_d = 1'b1;
      if (cap_ev && cheio)    ovf_d = 1'b1;
      if (aceita) begin
        count_d  = count_q + 5'd1;
        sum_d    = sum_q + SUM_W'(nota_in);
        ultima_d = nota_in;
        if (nota_in >= LIM_A_V)      na_d = na_q + 5'd1;
        else if (nota_in >= LIM_F_V) nf_d = nf_q + 5'd1;
        else                         np_d = np_q + 5'd1;
        state_d = (count_d == MAX_V) ? CHEIO : COLETA;
      end
    end
  end

  // State registers; edge samplers preset high so a held switch is ignored.
  always_ff @(posedge clk_2) begin
    if (reset) begin
      state_q   <= VAZIO;
      count_q   <= '0;
      sum_q     <= '0;
      na_q      <= '0;
      nf_q      <= '0;
      np_q      <= '0;
      ptr_q     <= '0;
      ultima_q  <= '0;
      ovf_q     <= 1'b0;
      rej_q     <= 1'b0;
      captura_q <= 1'b1;
      proximo_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      sum_q     <= sum_d;
      na_q      <= na_d;
      nf_q      <= nf_d;
      np_q      <= np_d;
      ptr_q     <= ptr_d;
      ultima_q  <= ultima_d;
      ovf_q     <= ovf_d;
      rej_q     <= rej_d;
      captura_q <= captura;
      proximo_q <= proximo;
    end
  end

  // Grade buffer; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk_2) begin
    if (!reset && aceita) begin
      notas[count_q[IDX_W-1:0]] <= nota_in;
    end
  end

  // Average category by cross-multiplication instead of division.
  always_comb begin
    sum_ext = PROD_W'(sum_q);
    prod_a  = PROD_W'(LIM_A_V) * PROD_W'(count_q);
    prod_f  = PROD_W'(LIM_F_V) * PROD_W'(count_q);
  end

  // Display source mux.
  always_comb begin
    SEG = SEG_VAZIO;
    case (modo)
      2'd0: SEG = cls(nota_in);
      2'd1: if (count_q != 5'd0) SEG = cls(ultima_q);
      2'd2: begin
        if (count_q != 5'd0) begin
          if (sum_ext >= prod_a)      SEG = SEG_A;
          else if (sum_ext >= prod_f) SEG = SEG_F;
          else                        SEG = SEG_P;
        end
      end
      default: if (count_q != 5'd0) SEG = cls(notas[ptr_q[IDX_W-1:0]]);
    endcase
  end

  // Status outputs.
  always_comb begin
    LED = {cheio, ovf_q, rej_q, count_q};
    n_A = na_q;
    n_F = nf_q;
    n_P = np_q;
  end

endmodule

// File: tb/tb_boletim_notas.sv
// Bench for boletim_notas: two instances (depth 16 and depth 4) share stimulus
// and are compared against a list-based model of the grade book.
module tb_boletim_notas;

  logic       clk_2;
  logic       reset;
  logic [3:0] nota;
  logic       captura, proximo, limpa;
  logic [1:0] modo;
  logic [7:0] seg [2];
  logic [7:0] led [2];
  logic [4:0] na [2];
  logic [4:0] nf [2];
  logic [4:0] np [2];

  int checks = 0;
  int errors = 0;

  boletim_notas dut16 (
    .clk_2(clk_2), .reset(reset), .nota_in(nota), .captura(captura), .proximo(proximo),
    .limpa(limpa), .modo(modo), .SEG(seg[0]), .LED(led[0]), .n_A(na[0]), .n_F(nf[0]),
    .n_P(np[0])
  );

  boletim_notas #(.MAX_ALUNOS(4)) dut4 (
    .clk_2(clk_2), .reset(reset), .nota_in(nota), .captura(captura), .proximo(proximo),
    .limpa(limpa), .modo(modo), .SEG(seg[1]), .LED(led[1]), .n_A(na[1]), .n_F(nf[1]),
    .n_P(np[1])
  );

  initial clk_2 = 1'b0;
  always #5 clk_2 = ~clk_2;

  // Model: list of stored grades per instance plus flags.
  int mmax [2] = '{16, 4};
  int mbuf [2][32];
  int mcnt [2];
  int mptr [2];
  int mult [2];
  int movf [2];
  int mrej [2];
  int cprev = 1, pprev = 1;

  task automatic model_clear(input int k);
    mcnt[k] = 0; mptr[k] = 0; mult[k] = 0; movf[k] = 0; mrej[k] = 0;
  endtask

  task automatic model_step();
    int cev, pev, pre, g;
    cev = (captura && !cprev) ? 1 : 0;
    pev = (proximo && !pprev) ? 1 : 0;
    g = int'(nota);
    if (reset) begin
      for (int k = 0; k < 2; k++) model_clear(k);
      cprev = 1; pprev = 1;
      return;
    end
    cprev = captura; pprev = proximo;
    for (int k = 0; k < 2; k++) begin
      if (limpa) model_clear(k);
      else begin
        pre = mcnt[k];
        if (pev != 0 && pre > 0) mptr[k] = (mptr[k] + 1) % pre;
        if (cev != 0) begin
          if (g > 10) mrej[k] = 1;
          if (pre == mmax[k]) movf[k] = 1;
          if (g <= 10 && pre < mmax[k]) begin
            mbuf[k][pre] = g; mcnt[k] = pre + 1; mult[k] = g;
          end
        end
      end
    end
  endtask

  function automatic logic [7:0] cls_m(input int g);
    if (g >= 7) return 8'h77;
    if (g >= 4) return 8'h71;
    return 8'h73;
  endfunction

  function automatic logic [7:0] exp_seg(input int k);
    int s;
    real avg;
    if (modo == 2'd0) return cls_m(int'(nota));
    if (mcnt[k] == 0) return 8'h00;
    if (modo == 2'd1) return cls_m(mult[k]);
    if (modo == 2'd3) return cls_m(mbuf[k][mptr[k]]);
    s = 0;
    for (int i = 0; i < mcnt[k]; i++) s += mbuf[k][i];
    avg = real'(s) / real'(mcnt[k]);
    if (avg >= 7.0) return 8'h77;
    if (avg >= 4.0) return 8'h71;
    return 8'h73;
  endfunction

  function automatic logic [7:0] exp_led(input int k);
    logic [7:0] v;
    v = 8'(mcnt[k]);
    v[7] = (mcnt[k] == mmax[k]);
    v[6] = (movf[k] != 0);
    v[5] = (mrej[k] != 0);
    return v;
  endfunction

  function automatic logic [4:0] exp_cat(input int k, input int cat);
    int n = 0;
    for (int i = 0; i < mcnt[k]; i++) begin
      if (cat == 0 && mbuf[k][i] >= 7) n++;
      if (cat == 1 && mbuf[k][i] >= 4 && mbuf[k][i] < 7) n++;
      if (cat == 2 && mbuf[k][i] < 4) n++;
    end
    return 5'(n);
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk_2);
    #1;
  endtask

  task automatic capture(input int v);
    nota = 4'(v); captura = 1'b1; tick();
    captura = 1'b0; tick();
  endtask

  task automatic step();
    proximo = 1'b1; tick();
    proximo = 1'b0; tick();
  endtask

  task automatic clear_pulse();
    limpa = 1'b1; tick();
    limpa = 1'b0; tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; captura = 1'b1; proximo = 1'b1; limpa = 1'b0; nota = 4'd9; modo = 2'd1;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (led[k] !== 8'h00) begin
        errors++; $display("FAIL reset_led[%0d]: got %h expected 00", k, led[k]);
      end
      checks++;
      if (seg[k] !== 8'h00) begin
        errors++; $display("FAIL reset_seg[%0d]: got %h expected 00", k, seg[k]);
      end
    end
    captura = 1'b0; proximo = 1'b0; tick();
  endtask

  task automatic test_capture_basic();
    logic [7:0] want [3] = '{8'h77, 8'h71, 8'h73};
    int grades [3] = '{9, 5, 2};
    modo = 2'd1;
    for (int i = 0; i < 3; i++) begin
      capture(grades[i]);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (seg[k] !== want[i]) begin
          errors++; $display("FAIL cap_seg[%0d] g=%0d: got %h expected %h", k, grades[i],
                             seg[k], want[i]);
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({na[k], nf[k], np[k], led[k][4:0]} !== {5'd1, 5'd1, 5'd1, 5'd3}) begin
        errors++; $display("FAIL cap_counts[%0d]: got A=%0d F=%0d P=%0d n=%0d expected 1 1 1 3",
                           k, na[k], nf[k], np[k], led[k][4:0]);
      end
    end
  endtask

  task automatic test_average();
    modo = 2'd2; #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (seg[k] !== 8'h71) begin
        errors++; $display("FAIL avg3_seg[%0d]: got %h expected 71", k, seg[k]);
      end
    end
    capture(10);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (seg[k] !== 8'h71) begin
        errors++; $display("FAIL avg4_seg[%0d]: got %h expected 71", k, seg[k]);
      end
    end
    checks++;
    if (led[1] !== 8'h84) begin
      errors++; $display("FAIL full4_led: got %h expected 84", led[1]);
    end
  endtask

  task automatic test_reject();
    logic [7:0] want1 [2] = '{8'h24, 8'hE4};
    logic [7:0] want2 [2] = '{8'h25, 8'hE4};
    capture(12);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (led[k] !== want1[k]) begin
        errors++; $display("FAIL rej_led[%0d]: got %h expected %h", k, led[k], want1[k]);
      end
    end
    capture(3);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (led[k] !== want2[k]) begin
        errors++; $display("FAIL rej_sticky[%0d]: got %h expected %h", k, led[k], want2[k]);
      end
    end
  endtask

  task automatic test_full();
    int grades [4] = '{1, 8, 4, 7};
    clear_pulse();
    foreach (grades[i]) capture(grades[i]);
    capture(3);
    checks++;
    if (led[1] !== 8'hC4) begin
      errors++; $display("FAIL ovf_led4: got %h expected c4", led[1]);
    end
    checks++;
    if (led[0] !== 8'h05) begin
      errors++; $display("FAIL ovf_led16: got %h expected 05", led[0]);
    end
    modo = 2'd1; #1;
    checks++;
    if (seg[1] !== 8'h77) begin
      errors++; $display("FAIL ovf_ultima4: got %h expected 77", seg[1]);
    end
    modo = 2'd3; #1;
    checks++;
    if (seg[1] !== 8'h73) begin
      errors++; $display("FAIL ovf_buf0: got %h expected 73", seg[1]);
    end
    step(); step(); step(); step();
    checks++;
    if (seg[1] !== 8'h73) begin
      errors++; $display("FAIL ovf_wrap4: got %h expected 73", seg[1]);
    end
  endtask

  task automatic test_review();
    logic [7:0] want [3] = '{8'h71, 8'h73, 8'h77};
    clear_pulse();
    capture(9); capture(5); capture(2);
    modo = 2'd3; #1;
    checks++;
    if (seg[0] !== 8'h77) begin
      errors++; $display("FAIL rev_start: got %h expected 77", seg[0]);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (seg[k] !== want[i]) begin
          errors++; $display("FAIL rev_step%0d[%0d]: got %h expected %h", i, k, seg[k],
                             want[i]);
        end
      end
    end
    clear_pulse();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({led[k], seg[k]} !== 16'h0000) begin
        errors++; $display("FAIL rev_clear[%0d]: got led=%h seg=%h expected 00 00", k,
                           led[k], seg[k]);
      end
    end
  endtask

  task automatic test_hold_and_same_cycle();
    modo = 2'd1;
    nota = 4'd6; captura = 1'b1;
    tick();
    checks++;
    if (led[0] !== 8'h01) begin
      errors++; $display("FAIL latency_led: got %h expected 01", led[0]);
    end
    repeat (5) tick();
    captura = 1'b0; tick();
    checks++;
    if (led[0] !== 8'h01) begin
      errors++; $display("FAIL hold_led: got %h expected 01", led[0]);
    end
    capture(9);
    step();
    // Step and capture together: pointer at 1 wraps against count 2.
    nota = 4'd2; captura = 1'b1; proximo = 1'b1; tick();
    captura = 1'b0; proximo = 1'b0; tick();
    modo = 2'd3; #1;
    checks++;
    if ({led[0], seg[0]} !== {8'h03, 8'h71}) begin
      errors++; $display("FAIL same_cycle: got led=%h seg=%h expected 03 71", led[0], seg[0]);
    end
    // Capture discarded when limpa is asserted in the same cycle.
    nota = 4'd8; captura = 1'b1; limpa = 1'b1; tick();
    captura = 1'b0; limpa = 1'b0; tick();
    checks++;
    if (led[0] !== 8'h00) begin
      errors++; $display("FAIL limpa_cap: got %h expected 00", led[0]);
    end
  endtask

  task automatic test_mode0();
    modo = 2'd0;
    for (int g = 0; g < 16; g++) begin
      nota = 4'(g); #1;
      checks++;
      if (seg[0] !== cls_m(g)) begin
        errors++; $display("FAIL mode0 g=%0d: got %h expected %h", g, seg[0], cls_m(g));
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      reset   = ($urandom_range(0, 79) == 0);
      limpa   = ($urandom_range(0, 39) == 0);
      captura = 1'($urandom);
      proximo = 1'($urandom);
      nota    = 4'($urandom_range(0, 12));
      modo    = 2'($urandom);
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (seg[k] !== exp_seg(k)) begin
          errors++; $display("FAIL rnd_seg[%0d] cyc %0d: got %h expected %h", k, n, seg[k],
                             exp_seg(k));
        end
        checks++;
        if (led[k] !== exp_led(k)) begin
          errors++; $display("FAIL rnd_led[%0d] cyc %0d: got %h expected %h", k, n, led[k],
                             exp_led(k));
        end
        checks++;
        if ({na[k], nf[k], np[k]} !== {exp_cat(k, 0), exp_cat(k, 1), exp_cat(k, 2)}) begin
          errors++; $display("FAIL rnd_cat[%0d] cyc %0d: got %0d %0d %0d expected %0d %0d %0d",
                             k, n, na[k], nf[k], np[k], exp_cat(k, 0), exp_cat(k, 1),
                             exp_cat(k, 2));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_capture_basic();
    test_average();
    test_reject();
    test_full();
    test_review();
    test_hold_and_same_cycle();
    test_mode0();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
